// File: rtl/io_bridge_pkg.sv
// Shared address map, timer control bit positions and data width for the
// MaquinaSencilla I/O peripheral bank.
package io_bridge_pkg;

    localparam int DATA_W = 16;

    localparam logic [4:0] ADDR_OUT0     = 5'h00;
    localparam logic [4:0] ADDR_OUT1     = 5'h01;
    localparam logic [4:0] ADDR_OUT2     = 5'h02;
    localparam logic [4:0] ADDR_OUT3     = 5'h03;
    localparam logic [4:0] ADDR_IN_RAW   = 5'h04;
    localparam logic [4:0] ADDR_IN_EDGE  = 5'h05;
    localparam logic [4:0] ADDR_TMR_LOAD = 5'h06;
    localparam logic [4:0] ADDR_TMR_CNT  = 5'h07;
    localparam logic [4:0] ADDR_TMR_CTRL = 5'h08;
    localparam logic [4:0] ADDR_TMR_PRE  = 5'h09;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_FLAG = 2;

endpackage

// File: rtl/io_timer.sv
// Prescaled down-counter timer: the prescaler emits a tick every PRE+1 cycles
// while enabled; each tick decrements CNT or, at zero, raises FLAG and reloads/stops.
module io_timer
    import io_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_load,
    input  logic              wr_cnt,
    input  logic              wr_ctrl,
    input  logic              wr_pre,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load,
    output logic [DATA_W-1:0] cnt,
    output logic [DATA_W-1:0] ctrl,
    output logic [DATA_W-1:0] pre,
    output logic              irq
);

    logic [DATA_W-1:0] load_q, load_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] pre_q, pre_d;
    logic [DATA_W-1:0] pre_cnt_q, pre_cnt_d;
    logic              en_q, en_d;
    logic              auto_q, auto_d;
    logic              flag_q, flag_d;
    logic              tick;
    logic              flag_set;

    always_comb begin
        tick      = 1'b0;
        pre_cnt_d = '0;
        if (en_q) begin
            if (pre_cnt_q == pre_q) begin
                tick = 1'b1;
            end else begin
                pre_cnt_d = pre_cnt_q + 16'd1;
            end
        end

        load_d   = wr_load ? wdata : load_q;
        pre_d    = wr_pre  ? wdata : pre_q;
        cnt_d    = cnt_q;
        en_d     = en_q;
        auto_d   = auto_q;
        flag_set = tick && (cnt_q == '0);

        if (tick) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 16'd1;
            end else if (auto_q) begin
                cnt_d = load_q;
            end else begin
                en_d = 1'b0;
            end
        end

        // CPU writes take priority over the tick, except that a new FLAG survives W1C
        if (wr_cnt) begin
            cnt_d = wdata;
        end
        if (wr_ctrl) begin
            en_d   = wdata[CTRL_EN];
            auto_d = wdata[CTRL_AUTO];
        end
        flag_d = flag_set | (flag_q & ~(wr_ctrl & wdata[CTRL_FLAG]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q    <= '0;
            cnt_q     <= '0;
            pre_q     <= '0;
            pre_cnt_q <= '0;
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            flag_q    <= 1'b0;
        end else begin
            load_q    <= load_d;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            pre_cnt_q <= pre_cnt_d;
            en_q      <= en_d;
            auto_q    <= auto_d;
            flag_q    <= flag_d;
        end
    end

    always_comb begin
        ctrl            = '0;
        ctrl[CTRL_EN]   = en_q;
        ctrl[CTRL_AUTO] = auto_q;
        ctrl[CTRL_FLAG] = flag_q;
    end

    assign load = load_q;
    assign cnt  = cnt_q;
    assign pre  = pre_q;
    assign irq  = flag_q;

endmodule

// File: rtl/io_port_bridge.sv
// I/O bus peripheral bank: address decode, output latches, synchronised inputs
// with sticky rising-edge flags, combinational read mux and the timer.
module io_port_bridge
    import io_bridge_pkg::*;
#(
    parameter int N_OUT       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4:0]              dirport,
    input  logic [DATA_W-1:0]       outport,
    input  logic                    we,
    output logic [DATA_W-1:0]       inport,
    input  logic [DATA_W-1:0]       in_pins,
    output logic [N_OUT*DATA_W-1:0] out_pins,
    output logic                    irq
);

    logic [DATA_W-1:0] out_q  [N_OUT];
    logic [DATA_W-1:0] out_d  [N_OUT];
    logic [DATA_W-1:0] sync_q [SYNC_STAGES];
    logic [DATA_W-1:0] sync_d [SYNC_STAGES];
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [DATA_W-1:0] edge_q, edge_d;
    logic [DATA_W-1:0] sync_now;
    logic [DATA_W-1:0] edge_det;
    logic [DATA_W-1:0] tmr_load, tmr_cnt, tmr_ctrl, tmr_pre;
    logic              wr_edge;

    assign sync_now = sync_q[SYNC_STAGES-1];
    assign edge_det = sync_now & ~prev_q;
    assign wr_edge  = we && (dirport == ADDR_IN_EDGE);

    always_comb begin
        sync_d[0] = in_pins;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        prev_d = sync_now;
        // A fresh edge on a bit being cleared keeps that bit set
        edge_d = edge_det | (edge_q & ~(wr_edge ? outport : '0));
        for (int k = 0; k < N_OUT; k++) begin
            out_d[k] = (we && (dirport == ADDR_OUT0 + 5'(k))) ? outport : out_q[k];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int k = 0; k < N_OUT; k++) begin
                out_q[k] <= '0;
            end
            prev_q <= '0;
            edge_q <= '0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int k = 0; k < N_OUT; k++) begin
                out_q[k] <= out_d[k];
            end
            prev_q <= prev_d;
            edge_q <= edge_d;
        end
    end

    io_timer u_timer (
        .clk     (clk),
        .rst_n   (reset),
        .wr_load (we && (dirport == ADDR_TMR_LOAD)),
        .wr_cnt  (we && (dirport == ADDR_TMR_CNT)),
        .wr_ctrl (we && (dirport == ADDR_TMR_CTRL)),
        .wr_pre  (we && (dirport == ADDR_TMR_PRE)),
        .wdata   (outport),
        .load    (tmr_load),
        .cnt     (tmr_cnt),
        .ctrl    (tmr_ctrl),
        .pre     (tmr_pre),
        .irq     (irq)
    );

    always_comb begin
        inport = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (dirport == ADDR_OUT0 + 5'(k)) begin
                inport = out_q[k];
            end
        end
        case (dirport)
            ADDR_IN_RAW:   inport = sync_now;
            ADDR_IN_EDGE:  inport = edge_q;
            ADDR_TMR_LOAD: inport = tmr_load;
            ADDR_TMR_CNT:  inport = tmr_cnt;
            ADDR_TMR_CTRL: inport = tmr_ctrl;
            ADDR_TMR_PRE:  inport = tmr_pre;
            default: ;
        endcase
    end

    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            out_pins[k*DATA_W +: DATA_W] = out_q[k];
        end
    end

endmodule

// File: tb/tb_io_port_bridge.sv
// Scoreboard bench for io_port_bridge: latches, input edge flags, timer modes
// and asynchronous reset.
module tb_io_port_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  dirport = '0;
    logic [15:0] outport = '0;
    logic        we = 1'b0;
    logic [15:0] inport;
    logic [15:0] in_pins = '0;
    logic [63:0] out_pins;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];

    io_port_bridge #(.N_OUT(4), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .dirport  (dirport),
        .outport  (outport),
        .we       (we),
        .inport   (inport),
        .in_pins  (in_pins),
        .out_pins (out_pins),
        .irq      (irq)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        dirport = a;
        outport = d;
        we      = 1'b1;
        tick();
        we      = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [15:0] e);
        dirport = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        check(tag_q.pop_front(), {48'd0, inport}, {48'd0, exp_q.pop_front()});
    endtask

    function automatic logic [15:0] oneshot_cnt(input int i);
        if (i < 4) return 16'd2;
        if (i < 8) return 16'd1;
        return 16'd0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held, inputs toggling
        repeat (4) begin
            in_pins = 16'($urandom);
            tick();
        end
        check("rst_out_pins", out_pins, 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        for (int a = 0; a < 10; a++) rd("rst_read", 5'(a), 16'h0000);
        rd("rst_read_1f", 5'h1F, 16'h0000);
        in_pins = '0;
        reset   = 1'b1;
        repeat (4) tick();

        // output latches and decode
        wr(5'h02, 16'hA5C3);
        check("out2_pins", 64'(out_pins[47:32]), 64'hA5C3);
        rd("out2_read", 5'h02, 16'hA5C3);
        wr(5'h1F, 16'hFFFF);
        rd("unmapped_read", 5'h1F, 16'h0000);
        check("unmapped_pins", out_pins, 64'h0000_A5C3_0000_0000);
        wr(5'h00, 16'h1234);
        wr(5'h03, 16'hBEEF);
        check("out_all_pins", out_pins, 64'hBEEF_A5C3_0000_1234);
        rd("out3_read", 5'h03, 16'hBEEF);
        wr(5'h04, 16'hFFFF);
        rd("raw_ro", 5'h04, 16'h0000);

        // rising-edge detection latency and W1C
        in_pins = 16'h0008;
        tick();
        rd("edge_lat1", 5'h05, 16'h0000);
        tick();
        rd("edge_lat2", 5'h05, 16'h0000);
        rd("raw_sync", 5'h04, 16'h0008);
        tick();
        rd("edge_lat3", 5'h05, 16'h0008);
        wr(5'h05, 16'h0008);
        rd("edge_w1c", 5'h05, 16'h0000);
        in_pins = 16'h0000;
        repeat (3) tick();
        rd("edge_fall", 5'h05, 16'h0000);
        in_pins = 16'h0008;
        tick();
        tick();
        wr(5'h05, 16'h0008);
        rd("edge_vs_clear", 5'h05, 16'h0008);
        wr(5'h05, 16'h0008);
        in_pins = 16'h0038;
        repeat (3) tick();
        rd("edge_multi", 5'h05, 16'h0030);
        wr(5'h05, 16'h0010);
        rd("edge_partial_w1c", 5'h05, 16'h0020);

        // one-shot timer
        wr(5'h09, 16'd3);
        wr(5'h06, 16'd2);
        wr(5'h07, 16'd2);
        rd("tmr_pre", 5'h09, 16'd3);
        rd("tmr_load", 5'h06, 16'd2);
        wr(5'h08, 16'h0001);
        for (int i = 1; i <= 12; i++) begin
            tick();
            rd("oneshot_cnt", 5'h07, oneshot_cnt(i));
            check("oneshot_irq", 64'(irq), (i >= 12) ? 64'd1 : 64'd0);
        end
        rd("oneshot_ctrl", 5'h08, 16'h0004);
        repeat (6) tick();
        rd("oneshot_hold_cnt", 5'h07, 16'd0);
        rd("oneshot_hold_ctrl", 5'h08, 16'h0004);
        wr(5'h08, 16'h0004);
        rd("flag_w1c", 5'h08, 16'h0000);
        check("flag_w1c_irq", 64'(irq), 64'd0);

        // auto-reload timer
        wr(5'h09, 16'd0);
        wr(5'h07, 16'd1);
        wr(5'h06, 16'd5);
        wr(5'h08, 16'h0003);
        tick();
        rd("auto_cnt1", 5'h07, 16'd0);
        check("auto_irq1", 64'(irq), 64'd0);
        tick();
        check("auto_irq2", 64'(irq), 64'd1);
        rd("auto_reload", 5'h07, 16'd5);
        tick();
        rd("auto_cnt3", 5'h07, 16'd4);
        wr(5'h08, 16'h0007);
        rd("auto_clr_ctrl", 5'h08, 16'h0003);
        check("auto_clr_irq", 64'(irq), 64'd0);
        rd("auto_running", 5'h07, 16'd3);
        wr(5'h07, 16'd9);
        rd("cnt_wr_wins", 5'h07, 16'd9);
        tick();
        rd("cnt_after_wr", 5'h07, 16'd8);
        wr(5'h07, 16'd0);
        rd("cnt_zero", 5'h07, 16'd0);
        rd("ctrl_noflag", 5'h08, 16'h0003);
        wr(5'h08, 16'h0007);
        rd("flag_beats_w1c", 5'h08, 16'h0007);
        check("flag_beats_w1c_irq", 64'(irq), 64'd1);
        rd("reload_on_ctrl_wr", 5'h07, 16'd5);

        // asynchronous reset between clock edges
        #4;
        reset = 1'b0;
        #1;
        check("arst_irq", 64'(irq), 64'd0);
        check("arst_out_pins", out_pins, 64'd0);
        rd("arst_cnt", 5'h07, 16'd0);
        rd("arst_ctrl", 5'h08, 16'h0000);
        rd("arst_load", 5'h06, 16'h0000);
        rd("arst_edge", 5'h05, 16'h0000);
        #2;
        reset = 1'b1;
        repeat (5) tick();
        rd("post_rst_cnt", 5'h07, 16'd0);
        rd("post_rst_ctrl", 5'h08, 16'h0000);
        check("post_rst_irq", 64'(irq), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
